i2c_slave_ctrl: RTL and testbench

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

---
 rtl/i2c_slave_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C slave that exposes a byte-addressed memory through a
// pointer. The master writes a word address and then data bytes, or reads
// sequentially from the pointer. All bus events are decoded from
// synchronized copies of SCL/SDA in the clk domain.
module i2c_slave_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  input  logic              sda,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, WADDR, WADDRACK, WRDATA, WRACK,
    RDLOAD, RDDATA, RDACK, WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              scl_s1_q, scl_s2_q, scl_h_q;
  logic              sda_s1_q, sda_s2_q, sda_h_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [1:0]        rd_step_q, rd_step_d;
  logic              rw_q, rw_d;
  logic              byte_done_q, byte_done_d;
  logic              sda_oe_q, sda_oe_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              busy_q, busy_d;

  logic              start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0]        rx_byte;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
      {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  // START/STOP need SCL high on both samples, so they never share a clk with
  // an SCL edge; the gating below keeps START/STOP dominant regardless.
  assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign scl_rise = scl_s2_q & ~scl_h_q & ~start_ev & ~stop_ev;
  assign scl_fall = ~scl_s2_q & scl_h_q & ~start_ev & ~stop_ev;
  assign rx_byte  = {shift_q[6:0], sda_s2_q};

  // Next-state and datapath decode for the protocol FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    rd_step_d   = rd_step_q;
    rw_d        = rw_q;
    byte_done_d = byte_done_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    we_d        = 1'b0;
    re_d        = 1'b0;

    // A completed write always advances the pointer, even if a STOP follows.
    if (we_q) ptr_d = ptr_q + ADDR_W'(1);

    if (start_ev) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      rd_step_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_ev) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      rd_step_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, WADDR, WRDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == DEVADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                  state_d = DEVACK;
                end else begin
                  state_d = WAIT;
                end
              end else if (state_q == WADDR) begin
                ptr_d   = ADDR_W'(rx_byte);
                state_d = WADDRACK;
              end else begin
                wdata_d = rx_byte;
                we_d    = 1'b1;
                state_d = WRACK;
              end
            end
          end
        end
        // Read direction leaves DEVACK on the ACK rise so the first data bit
        // is loaded before the fall that ends the ACK clock.
        DEVACK: begin
          if (scl_fall && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q && scl_rise && sda_oe_q) begin
            rd_step_d = '0;
            state_d   = RDLOAD;
          end else if (!rw_q && scl_fall && sda_oe_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WADDR;
          end
        end
        WADDRACK, WRACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = WRDATA;
            end
          end
        end
        // Step 0 strobes mem_re, step 1 waits for mem_rdata, step 2 captures.
        RDLOAD: begin
          case (rd_step_q)
            2'd0: begin
              re_d      = 1'b1;
              rd_step_d = 2'd1;
            end
            2'd1: rd_step_d = 2'd2;
            default: begin
              shift_d     = mem_rdata;
              ptr_d       = ptr_q + ADDR_W'(1);
              rd_step_d   = '0;
              bit_cnt_d   = '0;
              byte_done_d = 1'b0;
              state_d     = RDDATA;
            end
          endcase
        end
        RDDATA: begin
          if (scl_fall) begin
            if (byte_done_q) begin
              sda_oe_d = 1'b0;
              state_d  = RDACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end
        end
        RDACK: begin
          if (scl_rise) begin
            rd_step_d = '0;
            state_d   = sda_s2_q ? WAIT : RDLOAD;
          end
        end
        IDLE, WAIT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      rd_step_q   <= '0;
      rw_q        <= 1'b0;
      byte_done_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      rd_step_q   <= rd_step_d;
      rw_q        <= rw_d;
      byte_done_q <= byte_done_d;
      sda_oe_q    <= sda_oe_d;
      we_q        <= we_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed bus-level bench. A bit-banged I2C master drives
// SCL/SDA (open drain with the slave's sda_oe), and a byte memory model
// answers mem_we/mem_re with one-clk read latency.
module tb_i2c_slave_ctrl;

  localparam int Q = 8;  // clk periods per quarter of an SCL bit

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;

  logic [7:0] mem [256];
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl_m),
    .sda       (sda_bus),
    .sda_oe    (sda_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model and strobe logging.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (we_cnt < 16) begin
        wr_addr_log[we_cnt] <= mem_addr;
        wr_data_log[we_cnt] <= mem_wdata;
      end
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_cnt    <= re_cnt + 1;
    end
  end

  // Count clks during which the slave pulls SDA.
  always @(negedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~master_ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b want 0", mem_re); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int   we0 = we_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h10, a1);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    send_byte(8'h5A, a2);
    bus_stop();
    vectors++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
    vectors++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
    vectors++; if (wr_addr_log[we0] !== 8'h10) begin errors++; $display("FAIL write_addr: got %h want 10", wr_addr_log[we0]); end
    vectors++; if (wr_data_log[we0] !== 8'h5A) begin errors++; $display("FAIL write_data: got %h want 5a", wr_data_log[we0]); end
    vectors++; if (mem_addr !== 8'h11) begin errors++; $display("FAIL write_pointer: got %h want 11", mem_addr); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic       a0, a1, a2, a3, a4, a5, a6, b;
    logic [7:0] d0, d1;
    int         re0, oe0, we0;
    // Preload 0x20/0x21 through the slave itself.
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h20, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop();
    re0 = re_cnt;
    bus_start();
    send_byte(8'hA0, a4);
    send_byte(8'h20, a5);
    bus_start();
    send_byte(8'hA1, a6);
    recv_byte(d0, 1'b1);
    recv_byte(d1, 1'b0);
    vectors++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin errors++; $display("FAIL read_acks: got %b want 1111111", {a0, a1, a2, a3, a4, a5, a6}); end
    vectors++; if (d0 !== 8'h11) begin errors++; $display("FAIL read_byte0: got %h want 11", d0); end
    vectors++; if (d1 !== 8'h22) begin errors++; $display("FAIL read_byte1: got %h want 22", d1); end
    vectors++; if (re_cnt - re0 !== 2) begin errors++; $display("FAIL read_re_count: got %0d want 2", re_cnt - re0); end
    // After the NACK the slave must stay silent until START/STOP.
    oe0 = oe_cnt; we0 = we_cnt; re0 = re_cnt;
    for (int i = 0; i < 9; i++) recv_bit(b);
    bus_stop();
    vectors++; if (oe_cnt - oe0 !== 0) begin errors++; $display("FAIL read_wait_silent: got %0d oe clks want 0", oe_cnt - oe0); end
    vectors++; if ((re_cnt - re0) + (we_cnt - we0) !== 0) begin errors++; $display("FAIL read_wait_strobes: got %0d want 0", (re_cnt - re0) + (we_cnt - we0)); end
    vectors++; if (mem_addr !== 8'h22) begin errors++; $display("FAIL read_pointer: got %h want 22", mem_addr); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int   we0 = we_cnt;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a2);
    send_byte(8'hBB, a3);
    bus_stop();
    vectors++; if ({a0, a1, a2, a3} !== 4'hF) begin errors++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
    vectors++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL wrap_we_count: got %0d want 2", we_cnt - we0); end
    vectors++; if ({wr_addr_log[we0], wr_data_log[we0]} !== 16'hFFAA) begin errors++; $display("FAIL wrap_first: got %h want ffaa", {wr_addr_log[we0], wr_data_log[we0]}); end
    vectors++; if ({wr_addr_log[we0+1], wr_data_log[we0+1]} !== 16'h00BB) begin errors++; $display("FAIL wrap_second: got %h want 00bb", {wr_addr_log[we0+1], wr_data_log[we0+1]}); end
    vectors++; if (mem_addr !== 8'h01) begin errors++; $display("FAIL wrap_pointer: got %h want 01", mem_addr); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int   oe0 = oe_cnt;
    int   st0 = we_cnt + re_cnt;
    bus_start();
    send_byte(8'hA2, a0);
    send_byte(8'h00, a1);
    vectors++; if (a0 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack: got %b want 0", a0); end
    vectors++; if (oe_cnt - oe0 !== 0) begin errors++; $display("FAIL wrong_addr_oe: got %0d oe clks want 0", oe_cnt - oe0); end
    vectors++; if (we_cnt + re_cnt - st0 !== 0) begin errors++; $display("FAIL wrong_addr_strobes: got %0d want 0", we_cnt + re_cnt - st0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy: got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic test_partial_stop();
    logic a0, a1, b;
    int   we0 = we_cnt;
    int   oe0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h30, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    vectors++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL partial_we: got %0d want 0", we_cnt - we0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy: got %b want 0", busy); end
    vectors++; if (mem_addr !== 8'h30) begin errors++; $display("FAIL partial_pointer: got %h want 30", mem_addr); end
    // Idle: clocking a full frame without START must draw no ACK or strobe.
    oe0 = oe_cnt;
    for (int i = 0; i < 9; i++) recv_bit(b);
    vectors++; if (oe_cnt - oe0 + we_cnt - we0 !== 0) begin errors++; $display("FAIL partial_idle: got %0d activity want 0", oe_cnt - oe0 + we_cnt - we0); end
    bus_stop();
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, a4, a5;
    int   n, st0, oe0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h40, a1);
    send_byte(8'h00, a2);
    send_byte(8'h5C, a3);
    bus_stop();
    bus_start();
    send_byte(8'hA0, a4);
    send_byte(8'h40, a5);
    bus_start();
    send_byte(8'hA1, a0);
    // MSB of 0x00 is 0, so the slave should be pulling SDA for bit 7.
    n = 0;
    while (sda_oe !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vectors++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_oe_before: got %b want 1", sda_oe); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({sda_oe, mem_we, mem_re, busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctrl: got %b want 0000", {sda_oe, mem_we, mem_re, busy}); end
    vectors++; if ({mem_addr, mem_wdata} !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h want 0000", {mem_addr, mem_wdata}); end
    @(negedge clk);
    rst_n = 1'b1;
    st0 = we_cnt + re_cnt;
    oe0 = oe_cnt;
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    bus_stop();
    vectors++; if (oe_cnt - oe0 + we_cnt + re_cnt - st0 !== 0) begin errors++; $display("FAIL rst_mid_ignore: got %0d activity want 0", oe_cnt - oe0 + we_cnt + re_cnt - st0); end
    vectors++; if ({a1, a2, a3, a4, a5} !== 5'h1F) begin errors++; $display("FAIL rst_mid_setup_acks: got %b want 11111", {a1, a2, a3, a4, a5}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_wrong_addr();
    test_partial_stop();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
